mul_div_unit: RTL and testbench

//  Iterative 64-bit multiply/divide unit in the execute stage, beside the alu. Takes the

---
 rtl/mul_div_unit_pkg.sv | 19 +
 rtl/mul_div_unit_if.sv | 26 ++
 rtl/mul_div_unit.sv | 130 +++++++++++++
 tb/tb_mul_div_unit.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/mul_div_unit_pkg.sv
// Shared types and default width for the iterative multiply/divide unit.
package muldiv_pkg;

   localparam int unsigned N = 64;

   typedef enum logic [1:0] {
      OP_MUL   = 2'b00,
      OP_UMULH = 2'b01,
      OP_SDIV  = 2'b10,
      OP_UDIV  = 2'b11
   } muldiv_op_t;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } state_t;

endpackage

// File: rtl/mul_div_unit_if.sv
// Request/response bundle between the execute-stage control path and mul_div_unit.
interface mul_div_unit_if #(
   parameter int unsigned N = muldiv_pkg::N
);
   import muldiv_pkg::*;

   logic         start;
   muldiv_op_t   op;
   logic [N-1:0] a;
   logic [N-1:0] b;
   logic         busy;
   logic         done;
   logic [N-1:0] result;
   logic         div_zero;

   modport master (
      output start, op, a, b,
      input  busy, done, result, div_zero
   );

   modport slave (
      input  start, op, a, b,
      output busy, done, result, div_zero
   );

endinterface

// File: rtl/mul_div_unit.sv
// Iterative N-step shift-add multiplier / restoring divider sharing one 2N-bit register.
// Optional MULDIV_EARLY_OUT_EN: zero operands finish one cycle after accept.
module mul_div_unit #(
   parameter int unsigned N = muldiv_pkg::N
) (
   input logic           clk,
   input logic           reset,
   mul_div_unit_if.slave bus
);
   import muldiv_pkg::*;

   localparam int unsigned CntW = $clog2(N);

   state_t          state_q;
   muldiv_op_t      op_q;
   logic [N-1:0]    opnd_q;
   logic            neg_q;
   logic [CntW-1:0] cnt_q;
   logic [2*N-1:0]  acc_q;
   logic            busy_q;
   logic            done_q;
   logic [N-1:0]    result_q;
   logic            div_zero_q;

   logic           in_div;
   logic           in_sdiv;
   logic [N-1:0]   a_mag;
   logic [N-1:0]   b_mag;
   logic [N:0]     mul_sum;
   logic [N:0]     rem_sh;
   logic [N:0]     diff;
   logic [2*N-1:0] acc_step;
   logic [N-1:0]   quot;
   logic [N-1:0]   res_final;
   logic           dz_final;

   // Operand conditioning at accept: dividers work on magnitudes.
   always_comb begin
      in_div  = bus.op[1];
      in_sdiv = (bus.op == OP_SDIV);
      a_mag   = (in_sdiv && bus.a[N-1]) ? -bus.a : bus.a;
      b_mag   = (in_sdiv && bus.b[N-1]) ? -bus.b : bus.b;
   end

   // Multiply: acc = {partial_hi, multiplier}; divide: acc = {remainder, dividend/quotient}.
   always_comb begin
      mul_sum = {1'b0, acc_q[2*N-1:N]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
      rem_sh  = acc_q[2*N-1:N-1];
      diff    = rem_sh - {1'b0, opnd_q};
      if (op_q[1]) begin
         acc_step = diff[N] ? {rem_sh[N-1:0], acc_q[N-2:0], 1'b0}
                            : {diff[N-1:0], acc_q[N-2:0], 1'b1};
      end else begin
         acc_step = {mul_sum, acc_q[N-1:1]};
      end
   end

   always_comb begin
      quot     = acc_step[N-1:0];
      dz_final = op_q[1] && (opnd_q == '0);
      unique case (op_q)
         OP_MUL:   res_final = acc_step[N-1:0];
         OP_UMULH: res_final = acc_step[2*N-1:N];
         OP_SDIV:  res_final = dz_final ? '0 : (neg_q ? -quot : quot);
         OP_UDIV:  res_final = dz_final ? '0 : quot;
         default:  res_final = '0;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         op_q       <= OP_MUL;
         opnd_q     <= '0;
         neg_q      <= 1'b0;
         cnt_q      <= '0;
         acc_q      <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         result_q   <= '0;
         div_zero_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            IDLE, DONE: begin
               state_q <= IDLE;
               if (bus.start) begin
                  op_q   <= bus.op;
                  opnd_q <= in_div ? b_mag : bus.a;
                  acc_q  <= in_div ? {{N{1'b0}}, a_mag} : {{N{1'b0}}, bus.b};
                  neg_q  <= in_sdiv && (bus.a[N-1] ^ bus.b[N-1]);
                  cnt_q  <= '0;
`ifdef MULDIV_EARLY_OUT_EN
                  if ((bus.a == '0) || (bus.b == '0)) begin
                     state_q    <= DONE;
                     done_q     <= 1'b1;
                     result_q   <= '0;
                     div_zero_q <= in_div && (bus.b == '0);
                  end else begin
                     state_q <= RUN;
                     busy_q  <= 1'b1;
                  end
`else
                  state_q <= RUN;
                  busy_q  <= 1'b1;
`endif
               end
            end
            RUN: begin
               acc_q <= acc_step;
               cnt_q <= cnt_q + CntW'(1);
               if (cnt_q == CntW'(N - 1)) begin
                  state_q    <= DONE;
                  busy_q     <= 1'b0;
                  done_q     <= 1'b1;
                  result_q   <= res_final;
                  div_zero_q <= dz_final;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
   assign bus.result   = result_q;
   assign bus.div_zero = div_zero_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: driver pushes model results, monitor pops on done.
module tb_mul_div_unit;
   import muldiv_pkg::*;

   localparam int unsigned W = 64;

   logic clk = 1'b0;
   logic reset;
   int unsigned cyc = 0;
   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [W-1:0] res;
      logic         dz;
      int unsigned  due;
   } exp_t;

   exp_t exp_q[$];
   logic [W-1:0] last_res = '0;

   mul_div_unit_if #(.N(W)) bus ();

   mul_div_unit #(.N(W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, req);
      end
   endtask

   // Reference: plain wide arithmetic, truncating signed division.
   function automatic void ref_model(input muldiv_op_t op, input logic [W-1:0] a,
                                     input logic [W-1:0] b, output logic [W-1:0] r,
                                     output logic dz);
      logic [2*W-1:0] p;
      p  = {{W{1'b0}}, a} * {{W{1'b0}}, b};
      dz = 1'b0;
      r  = '0;
      case (op)
         OP_MUL:   r = p[W-1:0];
         OP_UMULH: r = p[2*W-1:W];
         OP_UDIV:  if (b == '0) dz = 1'b1; else r = a / b;
         OP_SDIV: begin
            if (b == '0) dz = 1'b1;
            else if (b == '1) r = -a;
            else r = $signed(a) / $signed(b);
         end
         default: r = '0;
      endcase
   endfunction

   always @(negedge clk) begin
      if (!reset && bus.done) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: got done=1 result=%h, expected no done", bus.result);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("result", bus.result, e.res);
            chk("div_zero", {63'b0, bus.div_zero}, {63'b0, e.dz});
            chk("done_cycle", W'(cyc), W'(e.due));
            chk("busy_at_done", {63'b0, bus.busy}, '0);
            last_res = e.res;
         end
      end
   end

   task automatic issue(input muldiv_op_t op, input logic [W-1:0] a, input logic [W-1:0] b);
      exp_t e;
      int n;
      logic eo;
      n = 0;
      @(negedge clk);
      while (bus.busy && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (bus.busy) begin
         checks++;
         errors++;
         $display("FAIL issue_timeout: got busy=1, expected idle within 200 cycles");
         return;
      end
      bus.start = 1'b1;
      bus.op    = op;
      bus.a     = a;
      bus.b     = b;
      ref_model(op, a, b, e.res, e.dz);
      eo = 1'b0;
`ifdef MULDIV_EARLY_OUT_EN
      eo = (a == '0) || (b == '0);
`endif
      @(posedge clk);
      #1;
      e.due = eo ? cyc : cyc + W;
      exp_q.push_back(e);
      bus.start = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (exp_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout: got %0d pending, expected 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   function automatic logic [W-1:0] pick();
      logic [W-1:0] v;
      case ($urandom_range(0, 7))
         0:       v = '0;
         1:       v = '1;
         2:       v = {1'b1, {(W-1){1'b0}}};
         3:       v = W'($urandom_range(0, 20));
         4:       v = -W'($urandom_range(1, 20));
         default: v = {$urandom, $urandom};
      endcase
      return v;
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      reset     = 1'b1;
      bus.start = 1'b0;
      bus.op    = OP_MUL;
      bus.a     = '0;
      bus.b     = '0;
      repeat (3) @(negedge clk);
      chk("reset_busy", {63'b0, bus.busy}, '0);
      chk("reset_done", {63'b0, bus.done}, '0);
      chk("reset_result", bus.result, '0);
      chk("reset_div_zero", {63'b0, bus.div_zero}, '0);
      reset = 1'b0;

      // Directed cases
      issue(OP_MUL, 64'd7, 64'd6);
      repeat (5) @(negedge clk);
      chk("busy_mid_run", {63'b0, bus.busy}, 64'd1);
      drain();
      issue(OP_UMULH, 64'h8000_0000_0000_0000, 64'd4);
      issue(OP_MUL, 64'h8000_0000_0000_0000, 64'd4);
      issue(OP_SDIV, -64'd7, 64'd2);
      issue(OP_UDIV, 64'd100, 64'd7);
      issue(OP_SDIV, 64'h8000_0000_0000_0000, '1);
      issue(OP_UDIV, 64'd5, 64'd0);
      issue(OP_SDIV, 64'd0, 64'd9);
      drain();
      repeat (3) @(negedge clk);
      chk("result_held", bus.result, last_res);

      // Start while busy, with new operands, is ignored
      issue(OP_MUL, 64'd1234, 64'd5678);
      repeat (10) @(negedge clk);
      chk("busy_before_ignored_start", {63'b0, bus.busy}, 64'd1);
      bus.start = 1'b1;
      bus.op    = OP_UDIV;
      bus.a     = 64'd999;
      bus.b     = 64'd0;
      @(negedge clk);
      bus.start = 1'b0;
      drain();

      // Reset mid-operation aborts with no done pulse
      issue(OP_MUL, 64'd3, 64'd5);
      repeat (30) @(negedge clk);
      reset = 1'b1;
      #1;
      exp_q.delete();
      chk("abort_busy", {63'b0, bus.busy}, '0);
      chk("abort_result", bus.result, '0);
      chk("abort_div_zero", {63'b0, bus.div_zero}, '0);
      @(negedge clk);
      reset = 1'b0;
      repeat (80) @(negedge clk);
      issue(OP_UDIV, 64'd1000, 64'd10);
      drain();

      // Randomized mix
      for (int i = 0; i < 40; i++) begin
         issue(muldiv_op_t'($urandom_range(0, 3)), pick(), pick());
         if ($urandom_range(0, 3) == 0) begin
            drain();
            repeat ($urandom_range(0, 3)) @(negedge clk);
         end
      end
      drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
